pipe_reg_file: RTL and testbench

//  Parametrised multi-port register file for the pipelined datapath; successor to the 32x32 two-read/one-write file.

---
 rtl/pipe_reg_file.sv | 109 ++++++++++
 tb/tb_pipe_reg_file.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_file.sv
// Parametrised multi-port register file with two write ports, optional write->read
// bypass, optional hard-wired zero register and a per-register pending-write scoreboard.
module pipe_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         RegWrite0,
  input  logic [ADDR_W-1:0]            WN0,
  input  logic [DATA_W-1:0]            WD0,
  input  logic                         RegWrite1,
  input  logic [ADDR_W-1:0]            WN1,
  input  logic [DATA_W-1:0]            WD1,
  input  logic [RD_PORTS*ADDR_W-1:0]   RN,
  output logic [RD_PORTS*DATA_W-1:0]   RD,
  output logic [RD_PORTS-1:0]          RBusy,
  input  logic                         Issue,
  input  logic [ADDR_W-1:0]            IssueWN,
  output logic                         AnyBusy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr0_ok = RegWrite0 && !is_zero_reg(WN0);
  assign wr1_ok = RegWrite1 && !is_zero_reg(WN1);
  assign iss_ok = Issue && !is_zero_reg(IssueWN);

  // Port 1 is applied after port 0 so it wins a collision; the issue is applied
  // last so a new producer keeps its register busy even if an older write lands.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[WN0] = WD0;
      busy_d[WN0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[WN1] = WD1;
      busy_d[WN1] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[IssueWN] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign AnyBusy = |busy_q;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;
    logic              rb_val;

    assign ra = RN[k*ADDR_W +: ADDR_W];

    // Reset and the zero register override bypass so nothing leaks through WD while cleared.
    always_comb begin
      rd_val = regs_q[ra];
      rb_val = busy_q[ra];
      if (BYPASS != 0) begin
        if (wr1_ok && (WN1 == ra)) begin
          rd_val = WD1;
          rb_val = 1'b0;
        end else if (wr0_ok && (WN0 == ra)) begin
          rd_val = WD0;
          rb_val = 1'b0;
        end
      end
      if (Reset || is_zero_reg(ra)) begin
        rd_val = '0;
        rb_val = 1'b0;
      end
    end

    assign RD[k*DATA_W +: DATA_W] = rd_val;
    assign RBusy[k]               = rb_val;
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Scoreboard bench for pipe_reg_file: two instances (32b/2-port/bypass/zero-reg and
// 64b/4-port/no-bypass/ordinary-r0) driven with directed and random traffic.
module tb_pipe_reg_file;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        we0 [2];
  logic        we1 [2];
  logic        iss [2];
  logic [4:0]  wn0 [2];
  logic [4:0]  wn1 [2];
  logic [4:0]  iwn [2];
  logic [63:0] wd0 [2];
  logic [63:0] wd1 [2];
  logic [4:0]  rn  [2][4];

  logic [63:0]  a_rd;
  logic [1:0]   a_rb;
  logic         a_any;
  logic [255:0] b_rd;
  logic [3:0]   b_rb;
  logic         b_any;

  pipe_reg_file #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .RegWrite0(we0[0]), .WN0(wn0[0]), .WD0(wd0[0][31:0]),
    .RegWrite1(we1[0]), .WN1(wn1[0]), .WD1(wd1[0][31:0]),
    .RN({rn[0][1], rn[0][0]}), .RD(a_rd), .RBusy(a_rb),
    .Issue(iss[0]), .IssueWN(iwn[0]), .AnyBusy(a_any)
  );

  pipe_reg_file #(.DATA_W(64), .ADDR_W(4), .RD_PORTS(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .RegWrite0(we0[1]), .WN0(wn0[1][3:0]), .WD0(wd0[1]),
    .RegWrite1(we1[1]), .WN1(wn1[1][3:0]), .WD1(wd1[1]),
    .RN({rn[1][3][3:0], rn[1][2][3:0], rn[1][1][3:0], rn[1][0][3:0]}),
    .RD(b_rd), .RBusy(b_rb),
    .Issue(iss[1]), .IssueWN(iwn[1][3:0]), .AnyBusy(b_any)
  );

  typedef struct packed {
    logic [1:0][3:0][63:0] rd;
    logic [1:0][3:0]       rb;
    logic [1:0]            any;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference state: what each register file should hold after every edge.
  logic [63:0] mem  [2][32];
  logic        busy [2][32];

  function automatic int  nports(int d);  return (d == 0) ? 2 : 4; endfunction
  function automatic bit  has_bp(int d);  return d == 0;           endfunction
  function automatic bit  has_zr(int d);  return d == 0;           endfunction
  function automatic logic [4:0] amask(int d, logic [4:0] a);
    return (d == 0) ? a : {1'b0, a[3:0]};
  endfunction
  function automatic logic [63:0] dmask(int d, logic [63:0] v);
    return (d == 0) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [4:0] a;
    e = '0;
    if (!Reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < nports(d); k++) begin
          a = rn[d][k];
          if (has_zr(d) && a == 0) begin
            e.rd[d][k] = '0;
            e.rb[d][k] = 1'b0;
          end else if (has_bp(d) && we1[d] && wn1[d] == a) begin
            e.rd[d][k] = wd1[d];
            e.rb[d][k] = 1'b0;
          end else if (has_bp(d) && we0[d] && wn0[d] == a) begin
            e.rd[d][k] = wd0[d];
            e.rb[d][k] = 1'b0;
          end else begin
            e.rd[d][k] = mem[d][a];
            e.rb[d][k] = busy[d][a];
          end
        end
        for (int r = 0; r < 32; r++) e.any[d] = e.any[d] | busy[d][r];
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) begin
        if (Reset) begin
          mem[d][r]  = '0;
          busy[d][r] = 1'b0;
        end
      end
      if (!Reset) begin
        if (we0[d] && !(has_zr(d) && wn0[d] == 0)) begin
          mem[d][wn0[d]]  = wd0[d];
          busy[d][wn0[d]] = 1'b0;
        end
        if (we1[d] && !(has_zr(d) && wn1[d] == 0)) begin
          mem[d][wn1[d]]  = wd1[d];
          busy[d][wn1[d]] = 1'b0;
        end
        if (iss[d] && !(has_zr(d) && iwn[d] == 0)) busy[d][iwn[d]] = 1'b1;
      end
    end
  endtask

  task automatic step();
    exp_q.push_back(predict());
    @(posedge Clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      we0[d] = 0; we1[d] = 0; iss[d] = 0;
      wn0[d] = '0; wn1[d] = '0; iwn[d] = '0; wd0[d] = '0; wd1[d] = '0;
      for (int k = 0; k < 4; k++) rn[d][k] = '0;
    end
  endtask

  task automatic w0(logic [4:0] a, logic [63:0] v);
    for (int d = 0; d < 2; d++) begin we0[d] = 1; wn0[d] = amask(d, a); wd0[d] = dmask(d, v); end
  endtask
  task automatic w1(logic [4:0] a, logic [63:0] v);
    for (int d = 0; d < 2; d++) begin we1[d] = 1; wn1[d] = amask(d, a); wd1[d] = dmask(d, v); end
  endtask
  task automatic issue(logic [4:0] a);
    for (int d = 0; d < 2; d++) begin iss[d] = 1; iwn[d] = amask(d, a); end
  endtask
  task automatic rd(int k, logic [4:0] a);
    for (int d = 0; d < 2; d++) rn[d][k] = amask(d, a);
  endtask

  function automatic logic [4:0] rnd_addr(int d);
    logic [4:0] a;
    a = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    return amask(d, a);
  endfunction

  task automatic chk(string nm, int d, int k, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d port%0d cyc=%0d got=%h exp=%h", nm, d, k, cyc, got, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk("rd", 0, k, {32'h0, a_rd[k*32 +: 32]}, e.rd[0][k]);
          chk("rbusy", 0, k, {63'h0, a_rb[k]}, {63'h0, e.rb[0][k]});
        end
        for (int k = 0; k < 4; k++) begin
          chk("rd", 1, k, b_rd[k*64 +: 64], e.rd[1][k]);
          chk("rbusy", 1, k, {63'h0, b_rb[k]}, {63'h0, e.rb[1][k]});
        end
        chk("anybusy", 0, 0, {63'h0, a_any}, {63'h0, e.any[0]});
        chk("anybusy", 1, 0, {63'h0, b_any}, {63'h0, e.any[1]});
      end
    end
  end

  initial begin
    int w;
    Reset = 1'b1;
    idle();
    for (int d = 0; d < 2; d++) for (int r = 0; r < 32; r++) begin mem[d][r] = '0; busy[d][r] = 0; end
    @(posedge Clk); #1;
    step();                                   // reset state
    Reset = 1'b0;
    // reset mid-operation
    idle(); w0(5, 64'hDEADBEEF); issue(6); rd(0, 5); step();
    idle(); rd(0, 5); rd(1, 6); step();
    Reset = 1'b1; w0(5, 64'h1); issue(7); step();
    Reset = 1'b0; idle(); rd(0, 5); rd(1, 6); step();
    step();
    // dual-write collision
    idle(); w0(7, 64'h11); w1(7, 64'h22); rd(0, 7); step();
    idle(); rd(0, 7); step();
    // bypass vs registered read
    idle(); w0(3, 64'h1234); rd(0, 3); step();
    idle(); rd(0, 3); step();
    // zero register
    idle(); w0(0, 64'hFFFF_FFFF_FFFF_FFFF); issue(0); rd(0, 0); rd(1, 0); step();
    idle(); rd(0, 0); rd(1, 0); step();
    idle(); w0(0, 64'h0); w1(0, 64'h0); step();   // clears r0 busy on the ordinary-r0 file
    // scoreboard
    idle(); issue(9); rd(0, 9); step();
    idle(); rd(0, 9); step();
    idle(); w0(9, 64'h5); rd(0, 9); step();
    idle(); rd(0, 9); step();
    idle(); issue(9); w1(9, 64'h6); rd(0, 9); step();
    idle(); rd(0, 9); step();
    idle(); issue(9); step();
    idle(); w0(9, 64'h7); rd(0, 9); step();
    // four-port read of r1..r4
    for (int i = 1; i <= 4; i++) begin idle(); w0(5'(i), 64'(i)); step(); end
    idle(); for (int k = 0; k < 4; k++) rd(k, 5'(k + 1)); step();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      Reset = ($urandom_range(0, 60) == 0);
      for (int d = 0; d < 2; d++) begin
        we0[d] = 1'($urandom_range(0, 1)); wn0[d] = rnd_addr(d); wd0[d] = dmask(d, {$urandom, $urandom});
        we1[d] = 1'($urandom_range(0, 2) == 0); wn1[d] = rnd_addr(d); wd1[d] = dmask(d, {$urandom, $urandom});
        iss[d] = 1'($urandom_range(0, 1)); iwn[d] = rnd_addr(d);
        for (int k = 0; k < 4; k++) rn[d][k] = ($urandom_range(0, 1) == 0) ? wn0[d] : rnd_addr(d);
      end
      step();
    end
    Reset = 1'b0; idle(); step();
    w = 0;
    while (exp_q.size() > 0 && w < 20) begin @(posedge Clk); w++; end
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
